// File: rtl/usb_tx.sv
// USB packet transmitter: SYNC, PID, optional payload + CRC16, EOP, NRZI-coded on D+/D-, 5 clk per bit.
// Define USB_TX_BIT_STUFF_EN to stuff a 0 after six consecutive 1s in PID, payload and CRC.
module usb_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       tx_error,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       Dplus_out,
    output logic       Dminus_out
);
    typedef enum logic [2:0] {IDLE, SYNC, PID, LOAD, DATA, CRC, EOP, ERR_EOP} state_t;

    state_t      state;
    logic [2:0]  cyc;
    logic [4:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  pid;
    logic [15:0] crc;
    logic [6:0]  byte_cnt;
    logic        is_data;
    logic        stuff_due;
    logic        send;
    logic        count_bit;
    logic        stuff;
    logic        tx_bit;

    function automatic logic valid_code(input logic [3:0] c);
        return c inside {4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011};
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // DATA0/DATA1 are the only codes ending in 11; handshakes end in 10.
    assign is_data = pid[0];
    assign get_tx_packet_data = !rst && (state == LOAD) && (buffer_occupancy != 7'd0)
                                && (byte_cnt != 7'd64);

`ifdef USB_TX_BIT_STUFF_EN
    logic [2:0] ones_cnt;
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || stuff) ones_cnt <= 3'd0;
        else if (count_bit)                ones_cnt <= tx_bit ? ones_cnt + 3'd1 : 3'd0;
    end
    assign stuff_due = (ones_cnt == 3'd6);
`else
    assign stuff_due = 1'b0;
`endif

    // Decide what goes on the wire at the coming bit boundary.
    always_comb begin
        send      = 1'b0;
        count_bit = 1'b0;
        stuff     = 1'b0;
        tx_bit    = 1'b1;
        if (cyc == 3'd4) begin
            case (state)
                SYNC: begin
                    send = 1'b1;
                    if (bit_cnt == 5'd8) begin
                        count_bit = 1'b1;
                        tx_bit    = pid[0];
                    end else begin
                        tx_bit = shreg[0];
                    end
                end
                PID, DATA, CRC: begin
                    if (stuff_due) begin
                        send   = 1'b1;
                        stuff  = 1'b1;
                        tx_bit = 1'b0;
                    end else if (bit_cnt != ((state == CRC) ? 5'd16 : 5'd8)) begin
                        send      = 1'b1;
                        count_bit = 1'b1;
                        tx_bit    = (state == CRC) ? ~crc[0] : shreg[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cyc                <= 3'd0;
            bit_cnt            <= 5'd0;
            shreg              <= 8'd0;
            pid                <= 8'd0;
            crc                <= 16'hFFFF;
            byte_cnt           <= 7'd0;
            tx_error           <= 1'b0;
            tx_transfer_active <= 1'b0;
            Dplus_out          <= 1'b1;
            Dminus_out         <= 1'b0;
        end else begin
            cyc <= (cyc == 3'd4) ? 3'd0 : cyc + 3'd1;
            if (send && !tx_bit) begin
                Dplus_out  <= ~Dplus_out;
                Dminus_out <= ~Dminus_out;
            end
            case (state)
                IDLE: begin
                    cyc      <= 3'd0;
                    crc      <= 16'hFFFF;
                    byte_cnt <= 7'd0;
                    tx_error <= 1'b0;
                    if (valid_code(tx_packet)) begin
                        state              <= SYNC;
                        pid                <= {~tx_packet, tx_packet};
                        shreg              <= 8'h40;  // SYNC 0x80 with its first bit already on the wire
                        bit_cnt            <= 5'd1;
                        tx_transfer_active <= 1'b1;
                        Dplus_out          <= 1'b0;
                        Dminus_out         <= 1'b1;
                    end
                end
                SYNC: if (send) begin
                    if (bit_cnt == 5'd8) begin
                        state   <= PID;
                        shreg   <= {1'b0, pid[7:1]};
                        bit_cnt <= 5'd1;
                    end else begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                PID, DATA: begin
                    if (count_bit) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    // Fetch the next byte while the last bit of this one is still on the wire.
                    if (cyc == 3'd2 && bit_cnt == 5'd8 && is_data) begin
                        state <= LOAD;
                    end else if (cyc == 3'd4 && bit_cnt == 5'd8 && !stuff) begin
                        state      <= EOP;
                        bit_cnt    <= 5'd1;
                        Dplus_out  <= 1'b0;
                        Dminus_out <= 1'b0;
                    end
                end
                LOAD: begin
                    bit_cnt <= 5'd0;
                    if (byte_cnt == 7'd64) begin
                        state <= CRC;
                    end else if (buffer_occupancy != 7'd0) begin
                        state    <= DATA;
                        shreg    <= tx_packet_data;
                        crc      <= crc_byte(crc, tx_packet_data);
                        byte_cnt <= byte_cnt + 7'd1;
                    end else if (byte_cnt != 7'd0) begin
                        state <= CRC;
                    end else begin
                        state    <= ERR_EOP;
                        tx_error <= 1'b1;
                    end
                end
                CRC: begin
                    if (count_bit) begin
                        crc     <= {1'b1, crc[15:1]};
                        bit_cnt <= bit_cnt + 5'd1;
                    end else if (cyc == 3'd4 && !stuff) begin
                        state      <= EOP;
                        bit_cnt    <= 5'd1;
                        Dplus_out  <= 1'b0;
                        Dminus_out <= 1'b0;
                    end
                end
                EOP, ERR_EOP: if (cyc == 3'd4) begin
                    // bit_cnt counts EOP bits already on the wire: two SE0, then J.
                    if (bit_cnt == 5'd2) begin
                        Dplus_out  <= 1'b1;
                        Dminus_out <= 1'b0;
                        bit_cnt    <= 5'd3;
                    end else if (bit_cnt == 5'd3) begin
                        state              <= IDLE;
                        tx_transfer_active <= 1'b0;
                        tx_error           <= 1'b0;
                    end else begin
                        Dplus_out  <= 1'b0;
                        Dminus_out <= 1'b0;
                        bit_cnt    <= bit_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: a bit-stream model builds the expected per-cycle line waveform of each packet,
// a negedge compare process checks every cycle against it, and a FIFO model feeds the payload.
module tb_usb_tx;
    logic       tb_clk = 1'b0;
    logic       rst;
    logic [3:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       tx_error;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       Dplus_out;
    logic       Dminus_out;

    usb_tx dut (
        .clk                (tb_clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .tx_error           (tx_error),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .Dplus_out          (Dplus_out),
        .Dminus_out         (Dminus_out)
    );

    always #5 tb_clk = ~tb_clk;

    // Expected per cycle: {err_care, err, active, dplus, dminus}
    logic [4:0] exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] pl_q[$];
    logic [1:0] sym_q[$];
    int         checks = 0;
    int         passed = 0;
    int         pops = 0;
    bit         pop_pending = 1'b0;
    bit         mon_en = 1'b0;
    bit         stuff_en;

    localparam int LIMIT = 6000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_valid(input logic [3:0] c);
        return (c == 4'b0010) || (c == 4'b1010) || (c == 4'b1110) || (c == 4'b0011) || (c == 4'b1011);
    endfunction

    function automatic logic [3:0] pick_invalid();
        logic [3:0] c;
        do c = 4'($urandom_range(0, 15)); while (is_valid(c));
        return c;
    endfunction

    // CRC16 (x^16+x^15+x^2+1, init all ones) over the first n bytes of pl_q, fed in wire order
    // through a shift-left register; result bit i is the i-th CRC bit put on the wire.
    function automatic logic [15:0] crc_tx_word(input int n);
        logic [15:0] c;
        logic [15:0] w;
        bit          fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ pl_q[k][i];
                c  = c << 1;
                if (fb) c = c ^ 16'h8005;
            end
        for (int i = 0; i < 16; i++) w[i] = ~c[15 - i];
        return w;
    endfunction

    // Builds sym_q: one {D+, D-} entry per bit time for the whole packet including EOP.
    task automatic model_packet(input logic [3:0] code, input int nbytes, input bit err);
        bit          raw[$];
        bit          body[$];
        logic [7:0]  pidb;
        logic [15:0] cw;
        int          ones;
        bit          lvl;
        sym_q.delete();
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        pidb = {~code, code};
        for (int i = 0; i < 8; i++) body.push_back(pidb[i]);
        if (!err && (code == 4'b0011 || code == 4'b1011)) begin
            for (int k = 0; k < nbytes; k++)
                for (int i = 0; i < 8; i++) body.push_back(pl_q[k][i]);
            cw = crc_tx_word(nbytes);
            for (int i = 0; i < 16; i++) body.push_back(cw[i]);
        end
        ones = 0;
        foreach (body[i]) begin
            raw.push_back(body[i]);
            ones = body[i] ? ones + 1 : 0;
            if (stuff_en && ones == 6) begin
                raw.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            sym_q.push_back({lvl, ~lvl});
        end
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b10);
    endtask

    // Expands sym_q to cycles; on an aborted packet the flag rises late in the last PID bit.
    task automatic push_exp(input bit err);
        logic [4:0] e;
        foreach (sym_q[j]) begin
            if (!err)        e = {2'b10, 1'b1, sym_q[j]};
            else if (j < 15) e = {2'b10, 1'b1, sym_q[j]};
            else if (j == 15) e = {2'b00, 1'b1, sym_q[j]};
            else             e = {2'b11, 1'b1, sym_q[j]};
            repeat (5) exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            tx_packet = pick_invalid();
            @(posedge tb_clk); #1;
        end
    endtask

    task automatic send_packet(input logic [3:0] code, input int nbytes, input bit err);
        int p0;
        int budget;
        int used;
        used = (nbytes > 64) ? 64 : nbytes;
        model_packet(code, used, err);
        fifo_q = pl_q;
        @(posedge tb_clk); #1;
        p0 = pops;
        tx_packet = code;
        @(posedge tb_clk); #1;
        push_exp(err);
        budget = 0;
        while (exp_q.size() > 3 && budget < LIMIT) begin
            tx_packet = 4'($urandom_range(0, 15));
            @(posedge tb_clk); #1;
            budget++;
        end
        tx_packet = pick_invalid();
        while (exp_q.size() > 0 && budget < LIMIT) begin
            @(posedge tb_clk); #1;
            budget++;
        end
        if (budget >= LIMIT) begin
            checks++;
            $display("FAIL packet_timeout: got %0d cycles, expected fewer than %0d", budget, LIMIT);
        end
        check("pop_count", pops - p0, (code[0] && !err) ? used : 0);
        fifo_q.delete();
        idle_cycles($urandom_range(3, 12));
    endtask

    // FIFO model: pops the head after the edge that consumed it, drives head and count.
    initial begin
        buffer_occupancy = 7'd0;
        tx_packet_data   = 8'd0;
        forever begin
            @(posedge tb_clk); #1;
            if (pop_pending) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pops++;
            end
            buffer_occupancy = 7'(fifo_q.size());
            tx_packet_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom_range(0, 255));
        end
    end

    // Compare process: every cycle, against the queued waveform or the idle state.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge tb_clk);
            if (mon_en) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b10010;
                check("lines", {Dplus_out, Dminus_out}, e[1:0]);
                check("active", tx_transfer_active, e[2]);
                if (e[4]) check("tx_error", tx_error, e[3]);
                if (!e[2]) check("idle_pop", get_tx_packet_data, 0);
                if (get_tx_packet_data) check("pop_nonempty", buffer_occupancy != 7'd0, 1);
            end
            pop_pending = get_tx_packet_data;
        end
    end

    initial begin
        logic [18:0] v;
        logic [3:0]  hs_codes[3];
        logic [3:0]  code;
        int          n;
`ifdef USB_TX_BIT_STUFF_EN
        stuff_en = 1'b1;
`else
        stuff_en = 1'b0;
`endif
        hs_codes = '{4'b0010, 4'b1010, 4'b1110};
        rst = 1'b1;
        tx_packet = 4'b0000;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        check("reset_dplus", Dplus_out, 1);
        check("reset_dminus", Dminus_out, 0);
        check("reset_error", tx_error, 0);
        check("reset_pop", get_tx_packet_data, 0);
        check("reset_active", tx_transfer_active, 0);
        @(posedge tb_clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Pin the model with hand-derived values.
        pl_q.delete();
        model_packet(4'b0010, 0, 1'b0);
        for (int j = 0; j < 19; j++) v[18 - j] = sym_q[j][1];
        check("model_ack_dplus", v, 19'b0101010011011000001);
        check("model_ack_len", sym_q.size(), 19);
        foreach (pl_q[i]) pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
        check("model_crc_check", crc_tx_word(9), 16'hB4C8);
        pl_q.delete();

        idle_cycles(6);
        foreach (hs_codes[i]) send_packet(hs_codes[i], 0, 1'b0);

        pl_q.delete(); pl_q.push_back(8'hAA);
        send_packet(4'b0011, 1, 1'b0);
        pl_q.delete(); pl_q.push_back(8'h55);
        send_packet(4'b1011, 1, 1'b0);
        pl_q.delete(); pl_q.push_back(8'hFF); pl_q.push_back(8'hFE);
        send_packet(4'b0011, 2, 1'b0);

        for (int p = 0; p < 8; p++) begin
            pl_q.delete();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
            code = $urandom_range(0, 1) ? 4'b1011 : 4'b0011;
            send_packet(code, n, 1'b0);
            send_packet(hs_codes[$urandom_range(0, 2)], 0, 1'b0);
        end

        // Payload cap: more bytes available than one packet may carry.
        pl_q.delete();
        for (int i = 0; i < 70; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        send_packet(4'b1011, 70, 1'b0);

        // Empty FIFO abort, then an invalid code must do nothing.
        pl_q.delete();
        send_packet(4'b0011, 0, 1'b1);
        tx_packet = 4'b1111;
        repeat (20) begin @(posedge tb_clk); #1; end

        // Reset in the middle of the payload.
        pl_q.delete();
        for (int i = 0; i < 3; i++) pl_q.push_back(8'h00);
        model_packet(4'b0011, 3, 1'b0);
        fifo_q = pl_q;
        @(posedge tb_clk); #1;
        tx_packet = 4'b0011;
        @(posedge tb_clk); #1;
        push_exp(1'b0);
        tx_packet = pick_invalid();
        repeat (92) begin @(posedge tb_clk); #1; end
        rst = 1'b1;
        @(posedge tb_clk); #1;
        exp_q.delete();
        @(negedge tb_clk);
        check("midrst_dplus", Dplus_out, 1);
        check("midrst_dminus", Dminus_out, 0);
        check("midrst_active", tx_transfer_active, 0);
        check("midrst_error", tx_error, 0);
        check("midrst_pop", get_tx_packet_data, 0);
        @(posedge tb_clk); #1;
        rst = 1'b0;
        fifo_q.delete();
        idle_cycles(10);
        pl_q.delete(); pl_q.push_back(8'h3C);
        send_packet(4'b0011, 1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
